// File: rtl/dwt_pkg.sv
// Shared sizes, timing limits and FSM state type for the DWT tile sequencer.
package dwt_pkg;

  localparam int DATA_W  = 64;
  localparam int ROWS    = 8;
  localparam int PTR_W   = $clog2(ROWS);

  // Cycles after issue before dwt_valid is trusted (stale pipeline flush).
  localparam int MIN_LAT = 4;
  // Cycles after issue at which the tile is captured regardless of dwt_valid.
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/dwt_row_buf.sv
// ROWS x DATA_W register file: single-row write, full parallel load,
// indexed read of one row and a flat read of all rows (row k at [64k+63:64k]).
module dwt_row_buf
  import dwt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [PTR_W-1:0]       wr_idx,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   ld_en,
  input  logic [ROWS*DATA_W-1:0] ld_data,
  input  logic [PTR_W-1:0]       rd_idx,
  output logic [DATA_W-1:0]      rd_data,
  output logic [ROWS*DATA_W-1:0] rd_all
);

  logic [DATA_W-1:0] mem [ROWS];

  // Storage: parallel load has priority over a single-row write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ROWS; k++) mem[k] <= '0;
    end else if (ld_en) begin
      for (int k = 0; k < ROWS; k++) mem[k] <= ld_data[k*DATA_W +: DATA_W];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Flat view of the whole tile, row 0 in the low bits.
  always_comb begin
    rd_all = '0;
    for (int k = 0; k < ROWS; k++) rd_all[k*DATA_W +: DATA_W] = mem[k];
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dwt_tile_ctrl.sv
// Tile sequencer for the 8x8 2D-DWT: gathers eight rows, holds them on the
// DWT inputs until coefficients are valid (or a timeout), then streams the
// eight coefficient rows out one per handshake.
//
//   state | meaning
//   LOAD  | accepting upstream rows into the input buffer
//   WAIT  | tile issued to DWT; counting latency, waiting for dwt_valid
//   DRAIN | coefficient rows presented downstream, one per handshake
module dwt_tile_ctrl
  import dwt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_data,
  output logic [ROWS*DATA_W-1:0] dwt_inp,
  input  logic [ROWS*DATA_W-1:0] dwt_outp,
  input  logic                   dwt_valid,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [2:0]             m_row,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [15:0]            tile_count
);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s_acc, m_acc;
  logic             cap, cap_to;

  // The input buffer is only read flat and the output buffer only by index;
  // the other read port of each is left dangling.
  logic [DATA_W-1:0]      in_buf_rd_unused;
  logic [ROWS*DATA_W-1:0] out_buf_all_unused;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next state, handshake outputs and capture decision.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b0;
    cap     = 1'b0;
    cap_to  = 1'b0;
    case (state_q)
      LOAD: begin
        // Held low during reset so nothing is accepted into a tile being discarded.
        s_ready = !rst;
        if (s_valid && !rst && wr_ptr_q == PTR_W'(ROWS - 1)) state_d = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        cap_to = (cnt_q == CNT_W'(TIMEOUT));
        cap    = ((cnt_q >= CNT_W'(MIN_LAT)) && dwt_valid) || cap_to;
        if (cap) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (m_ready && rd_ptr_q == PTR_W'(ROWS - 1)) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign s_acc = s_valid && s_ready;
  assign m_acc = m_valid && m_ready;

  // Row pointers, latency counter and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_timeout <= 1'b0;
      tile_count  <= '0;
    end else begin
      // Pointers wrap 7 -> 0 on the last row, which leaves them ready for the next tile.
      if (s_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (m_acc) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (state_q != WAIT)                 cnt_q <= '0;
      else if (cnt_q != CNT_W'(TIMEOUT))   cnt_q <= cnt_q + 1'b1;

      // A timeout capture with dwt_valid also high at that cycle is a normal capture.
      if (cap_to && !dwt_valid) err_timeout <= 1'b1;

      if (m_acc && rd_ptr_q == PTR_W'(ROWS - 1)) tile_count <= tile_count + 16'd1;
    end
  end

  dwt_row_buf u_in_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_acc),
    .wr_idx  (wr_ptr_q),
    .wr_data (s_data),
    .ld_en   (1'b0),
    .ld_data ('0),
    .rd_idx  ('0),
    .rd_data (in_buf_rd_unused),
    .rd_all  (dwt_inp)
  );

  dwt_row_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (1'b0),
    .wr_idx  ('0),
    .wr_data ('0),
    .ld_en   (cap),
    .ld_data (dwt_outp),
    .rd_idx  (rd_ptr_q),
    .rd_data (m_data),
    .rd_all  (out_buf_all_unused)
  );

  assign m_row = rd_ptr_q;

endmodule

// File: tb/tb_dwt_tile_ctrl.sv
// Self-checking bench for dwt_tile_ctrl: table of tile scenarios plus
// hand-written reset and counter-wrap sequences, with a row scoreboard.
module tb_dwt_tile_ctrl;
  import dwt_pkg::*;

  localparam logic [DATA_W-1:0] ONES = '1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_W-1:0]      s_data;
  logic [ROWS*DATA_W-1:0] dwt_inp;
  logic [ROWS*DATA_W-1:0] dwt_outp;
  logic                   dwt_valid;
  logic                   m_valid;
  logic                   m_ready;
  logic [DATA_W-1:0]      m_data;
  logic [2:0]             m_row;
  logic                   busy;
  logic                   err_timeout;
  logic [15:0]            tile_count;

  always #5 clk = ~clk;

  // DWT stand-in: coefficients are the inputs inverted.
  assign dwt_outp = dwt_inp ^ {ROWS{ONES}};

  dwt_tile_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .dwt_inp     (dwt_inp),
    .dwt_outp    (dwt_outp),
    .dwt_valid   (dwt_valid),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_row       (m_row),
    .busy        (busy),
    .err_timeout (err_timeout),
    .tile_count  (tile_count)
  );

  typedef struct {
    logic [DATA_W-1:0] seed;      // row r = seed * (r+1)
    int                dv_from;   // dwt_valid high from this WAIT cycle on; 0 = high always; -1 = never
    int                dv_pulse;  // single-cycle dwt_valid pulse at this WAIT cycle; -1 = none
    bit                bp;        // m_ready pattern 1,0,0,1 during DRAIN
    int                exp_wait;  // required number of cycles spent in WAIT
    bit                exp_err;   // required err_timeout after the tile
  } vec_t;

  typedef struct {
    logic [2:0]        row;
    logic [DATA_W-1:0] data;
  } exp_t;

  vec_t        vecs [6];
  exp_t        sb_q [$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] exp_count = '0;

  function automatic void chk1(string name, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endfunction

  function automatic void chkd(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void chkw(string name, logic [ROWS*DATA_W-1:0] act, logic [ROWS*DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held over one edge; every output must read zero while rst is high.
  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; dwt_valid = 1'b0;
    #1;
    chk1("rst_s_ready_now", s_ready, 1'b0);
    tick();
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err_timeout, 1'b0);
    chkd("rst_tile_count", 64'(tile_count), 64'd0);
    chkd("rst_m_data", m_data, 64'd0);
    chkd("rst_m_row", 64'(m_row), 64'd0);
    chkw("rst_dwt_inp", dwt_inp, '0);
    rst = 1'b0;
    #1;
    chk1("post_rst_s_ready", s_ready, 1'b1);
    sb_q.delete();
    exp_count = '0;
    tick();
  endtask

  // Offer n rows then stop; used to leave a partial tile in the buffer.
  task automatic load_partial(input logic [DATA_W-1:0] seed, input int n);
    int acc = 0;
    int guard = 0;
    while (acc < n && guard < 40) begin
      s_valid = 1'b1; s_data = seed * 64'(acc + 1); m_ready = 1'b1; dwt_valid = 1'b0;
      #1;
      if (s_ready) acc++;
      tick();
      guard++;
    end
    s_valid = 1'b0;
    chkd("partial_rows", 64'(acc), 64'(n));
  endtask

  // One full tile; returns early after stop_drain handshakes if stop_drain >= 0.
  task automatic run_tile(input vec_t v, input int stop_drain);
    logic [DATA_W-1:0]      rows [ROWS];
    logic [ROWS*DATA_W-1:0] exp_inp;
    int acc = 0;
    int wcnt = 0;
    int k = 0;
    int hs = 0;
    int guard = 0;
    for (int r = 0; r < ROWS; r++) begin
      rows[r] = v.seed * 64'(r + 1);
      exp_inp[r*DATA_W +: DATA_W] = rows[r];
    end

    while (acc < ROWS && guard < 40) begin
      s_valid = 1'b1; s_data = rows[acc]; m_ready = 1'b1; dwt_valid = (v.dv_from == 0);
      #1;
      chk1("load_m_valid", m_valid, 1'b0);
      if (s_ready) begin
        sb_q.push_back('{row: 3'(acc), data: rows[acc] ^ ONES});
        acc++;
      end
      tick();
      guard++;
    end
    s_valid = 1'b0; s_data = '0;
    chkd("load_rows", 64'(acc), 64'(ROWS));

    guard = 0;
    while (guard < 200) begin
      dwt_valid = (v.dv_from >= 0 && wcnt >= v.dv_from) || (wcnt == v.dv_pulse);
      #1;
      if (m_valid) break;
      chk1("wait_busy", busy, 1'b1);
      if (wcnt == 0) begin
        chk1("wait_s_ready", s_ready, 1'b0);
        chkd("wait_inp_row0", dwt_inp[DATA_W-1:0], rows[0]);
        chkw("wait_inp", dwt_inp, exp_inp);
      end
      wcnt++;
      tick();
      guard++;
    end
    chkd("wait_len", 64'(wcnt), 64'(v.exp_wait));

    guard = 0;
    while (hs < ROWS && guard < 200) begin
      if (v.bp) begin
        case (k % 4)
          0, 3:    m_ready = 1'b1;
          default: m_ready = 1'b0;
        endcase
      end else begin
        m_ready = 1'b1;
      end
      #1;
      chk1("drain_m_valid", m_valid, 1'b1);
      if (k == 0) chkw("drain_inp", dwt_inp, exp_inp);
      if (sb_q.size() == 0) begin
        chkd("drain_sb_empty", 64'd1, 64'd0);
      end else begin
        chkd("drain_m_data", m_data, sb_q[0].data);
        chkd("drain_m_row", 64'(m_row), 64'(sb_q[0].row));
        if (m_valid && m_ready) begin
          void'(sb_q.pop_front());
          hs++;
        end
      end
      k++;
      tick();
      guard++;
      if (hs == stop_drain) return;
    end
    chkd("drain_rows", 64'(hs), 64'(ROWS));

    exp_count = exp_count + 16'd1;
    m_ready = 1'b1;
    #1;
    chk1("end_m_valid", m_valid, 1'b0);
    chk1("end_busy", busy, 1'b0);
    chk1("end_s_ready", s_ready, 1'b1);
    chkd("end_tile_count", 64'(tile_count), 64'(exp_count));
    chk1("end_err", err_timeout, v.exp_err);
    chkd("end_sb_left", 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    vecs[0] = '{seed: 64'h0101010101010101, dv_from: 5,  dv_pulse: -1, bp: 1'b0, exp_wait: 6,  exp_err: 1'b0};
    vecs[1] = '{seed: 64'h0101010101010101, dv_from: 5,  dv_pulse: -1, bp: 1'b1, exp_wait: 6,  exp_err: 1'b0};
    vecs[2] = '{seed: 64'h0123456789ABCDEF, dv_from: 0,  dv_pulse: -1, bp: 1'b0, exp_wait: 5,  exp_err: 1'b0};
    vecs[3] = '{seed: 64'h00FF00FF00FF00FF, dv_from: -1, dv_pulse: 3,  bp: 1'b0, exp_wait: 65, exp_err: 1'b1};
    vecs[4] = '{seed: 64'h8040201008040201, dv_from: 4,  dv_pulse: -1, bp: 1'b1, exp_wait: 5,  exp_err: 1'b1};
    vecs[5] = '{seed: 64'hDEADBEEFCAFEF00D, dv_from: 63, dv_pulse: -1, bp: 1'b1, exp_wait: 64, exp_err: 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; dwt_valid = 1'b0;
    tick();
    do_reset();

    for (int i = 0; i < 6; i++) run_tile(vecs[i], -1);

    // Reset after five rows: partial tile discarded, next tile starts at row 0.
    load_partial(64'h5555555555555555, 5);
    do_reset();
    run_tile(vecs[0], -1);

    // Reset in DRAIN after row 3: nothing more is emitted.
    run_tile(vecs[2], 4);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b0; m_ready = 1'b1; dwt_valid = 1'b1;
      #1;
      chk1("idle_m_valid", m_valid, 1'b0);
      tick();
    end

    // Counter wrap.
    force dut.tile_count = 16'hFFFF;
    tick();
    release dut.tile_count;
    #1;
    chkd("wrap_preset", 64'(tile_count), 64'hFFFF);
    exp_count = 16'hFFFF;
    tick();
    run_tile(vecs[0], -1);
    chkd("wrap_zero", 64'(tile_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
